// File: rtl/pifo_pkg.sv
// Shared types and default widths for the PIFO pop-side collector and its output queue.
package pifo_pkg;

    localparam int PTW    = 8;
    localparam int LEVEL  = 4;
    localparam int TREE_W = $clog2(LEVEL);

    typedef struct packed {
        logic              vld;
        logic [TREE_W-1:0] tree;
    } pop_tag_t;

    typedef struct packed {
        logic [TREE_W-1:0] tree;
        logic [PTW-1:0]    data;
    } deq_ent_t;

    function automatic logic [LEVEL-1:0] tree_onehot(input logic [TREE_W-1:0] tree);
        return LEVEL'(1) << tree;
    endfunction

endpackage

// File: rtl/pifo_pop_oq.sv
// Output queue of returned PIFO elements: synchronous FIFO of deq_ent_t with occupancy count.
module pifo_pop_oq
    import pifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  deq_ent_t                 i_wr_ent,
    input  logic                     i_rd_en,
    output deq_ent_t                 o_rd_ent,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    deq_ent_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_wr;
    logic            do_rd;

    assign o_empty = (o_count == '0);
    assign do_rd   = i_rd_en && !o_empty;
    // A write into a full queue is accepted only when the head leaves in the same cycle.
    assign do_wr   = i_wr_en && ((o_count != (AW+1)'(DEPTH)) || do_rd);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is not reset; validity comes from the pointers and count, so it maps to plain RAM.
    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wr_ptr] <= i_wr_ent;
    end

    assign o_rd_ent = o_empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pifo_pop_collector.sv
// Pop-side collector for the PIFO: credit-gated pop issue, fixed-latency capture, tagged output stream.
// Optional PIFO_POP_STATS_EN adds wrapping counters o_stat_pops / o_stat_errs.
module pifo_pop_collector
    import pifo_pkg::*;
#(
    parameter int POP_LAT  = 1,
    parameter int CNT_W    = 8,
    parameter int OQ_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [LEVEL-1:0]         i_push_mon,
    input  logic                     i_req_valid,
    input  logic [TREE_W-1:0]        i_req_tree,
    output logic                     o_req_ready,
    output logic                     o_req_err,
    output logic [LEVEL-1:0]         o_pop,
    output logic [LEVEL*TREE_W-1:0]  o_tree_id,
    input  logic [LEVEL*PTW-1:0]     i_pop_data,
    output logic                     o_deq_valid,
    output logic [PTW-1:0]           o_deq_data,
    output logic [TREE_W-1:0]        o_deq_tree,
    input  logic                     i_deq_ready,
    output logic [LEVEL*CNT_W-1:0]   o_occ
`ifdef PIFO_POP_STATS_EN
    ,
    output logic [31:0]              o_stat_pops,
    output logic [31:0]              o_stat_errs
`endif
);

    localparam int OQ_CW = $clog2(OQ_DEPTH) + 1;
    localparam int CR_W  = $clog2(POP_LAT + OQ_DEPTH + 2);

    logic                 rst_q;
    logic [CNT_W-1:0]     occ [LEVEL];
    pop_tag_t             issue_q;
    pop_tag_t             pipe [POP_LAT];
    pop_tag_t             tail;
    logic [CR_W-1:0]      inflight;
    logic [OQ_CW-1:0]     oq_count;
    logic                 oq_empty;
    logic                 req_acc;
    logic                 req_empty;
    logic                 pop_hit;
    logic [LEVEL-1:0]     pop_dec;
    deq_ent_t             cap_ent;
    deq_ent_t             head_ent;

    // Credit: every issued pop owns an OQ slot from issue until it is dequeued.
    always_comb begin
        inflight = CR_W'(issue_q.vld);
        for (int i = 0; i < POP_LAT; i++) begin
            inflight = inflight + CR_W'(pipe[i].vld);
        end
    end

    assign o_req_ready = !rst_q && ((inflight + CR_W'(oq_count)) < CR_W'(OQ_DEPTH));
    assign req_acc     = i_req_valid && o_req_ready;
    assign req_empty   = (occ[i_req_tree] == '0);
    assign pop_hit     = req_acc && !req_empty;
    assign pop_dec     = pop_hit ? tree_onehot(i_req_tree) : '0;

    always_ff @(posedge i_clk) begin
        rst_q <= i_rst;
        if (i_rst) begin
            o_pop     <= '0;
            o_req_err <= 1'b0;
            issue_q   <= '0;
            for (int i = 0; i < POP_LAT; i++) begin
                pipe[i] <= '0;
            end
            for (int t = 0; t < LEVEL; t++) begin
                occ[t] <= '0;
            end
        end else begin
            o_pop        <= pop_dec;
            o_req_err    <= req_acc && req_empty;
            issue_q.vld  <= pop_hit;
            issue_q.tree <= i_req_tree;
            // Tag leaves issue_q as the PIFO samples o_pop; tail reaches capture as pop data turns valid.
            pipe[0] <= issue_q;
            for (int i = 1; i < POP_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            for (int t = 0; t < LEVEL; t++) begin
                if (i_push_mon[t] && !pop_dec[t]) begin
                    if (occ[t] != '1) occ[t] <= occ[t] + 1'b1;
                end else if (pop_dec[t] && !i_push_mon[t]) begin
                    occ[t] <= occ[t] - 1'b1;
                end
            end
        end
    end

    assign tail = pipe[POP_LAT-1];

    always_comb begin
        cap_ent.tree = tail.tree;
        cap_ent.data = i_pop_data[tail.tree*PTW +: PTW];
    end

    pifo_pop_oq #(
        .DEPTH (OQ_DEPTH)
    ) u_oq (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr_en  (tail.vld),
        .i_wr_ent (cap_ent),
        .i_rd_en  (i_deq_ready),
        .o_rd_ent (head_ent),
        .o_empty  (oq_empty),
        .o_count  (oq_count)
    );

    assign o_deq_valid = !oq_empty;
    assign o_deq_data  = head_ent.data;
    assign o_deq_tree  = head_ent.tree;

    for (genvar t = 0; t < LEVEL; t++) begin : g_tree_id
        assign o_tree_id[t*TREE_W +: TREE_W] = TREE_W'(t);
    end

    // NOTE: combinational blocks assign a default first so no path can leave a bit unassigned and infer a latch.
    always_comb begin
        o_occ = '0;
        for (int t = 0; t < LEVEL; t++) begin
            o_occ[t*CNT_W +: CNT_W] = occ[t];
        end
    end

`ifdef PIFO_POP_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stat_pops <= '0;
            o_stat_errs <= '0;
        end else begin
            if (pop_hit)               o_stat_pops <= o_stat_pops + 32'd1;
            if (req_acc && req_empty)  o_stat_errs <= o_stat_errs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pifo_pop_collector.sv
// Self-checking bench for pifo_pop_collector: behavioural PIFO lanes plus a scoreboard of returned elements.
module tb_pifo_pop_collector;

    localparam int LEVEL  = 4;
    localparam int PTW    = 8;
    localparam int TREE_W = 2;
    localparam int CNT_W  = 8;

    logic                     clk = 1'b0;
    logic                     i_rst;
    logic [LEVEL-1:0]         i_push_mon;
    logic                     i_req_valid;
    logic [TREE_W-1:0]        i_req_tree;
    logic                     o_req_ready;
    logic                     o_req_err;
    logic [LEVEL-1:0]         o_pop;
    logic [LEVEL*TREE_W-1:0]  o_tree_id;
    logic [LEVEL*PTW-1:0]     i_pop_data;
    logic                     o_deq_valid;
    logic [PTW-1:0]           o_deq_data;
    logic [TREE_W-1:0]        o_deq_tree;
    logic                     i_deq_ready;
    logic [LEVEL*CNT_W-1:0]   o_occ;
`ifdef PIFO_POP_STATS_EN
    logic [31:0]              o_stat_pops;
    logic [31:0]              o_stat_errs;
`endif

    always #5 clk = ~clk;

    pifo_pop_collector dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_push_mon  (i_push_mon),
        .i_req_valid (i_req_valid),
        .i_req_tree  (i_req_tree),
        .o_req_ready (o_req_ready),
        .o_req_err   (o_req_err),
        .o_pop       (o_pop),
        .o_tree_id   (o_tree_id),
        .i_pop_data  (i_pop_data),
        .o_deq_valid (o_deq_valid),
        .o_deq_data  (o_deq_data),
        .o_deq_tree  (o_deq_tree),
        .i_deq_ready (i_deq_ready),
        .o_occ       (o_occ)
`ifdef PIFO_POP_STATS_EN
        ,
        .o_stat_pops (o_stat_pops),
        .o_stat_errs (o_stat_errs)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  pifo_q [LEVEL][$];
    logic [7:0]  exp_q  [LEVEL][$];
    logic [9:0]  sb [$];
    int          occ_m [LEVEL];
    int          pops_m = 0;
    int          errs_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input int t, input logic [7:0] d);
        if (occ_m[t] < 255) begin
            occ_m[t]++;
            pifo_q[t].push_back(d);
            exp_q[t].push_back(d);
        end
    endtask

    task automatic push_cycle(input logic [3:0] mask, input int base);
        i_push_mon = mask;
        tick();
        i_push_mon = '0;
        for (int t = 0; t < LEVEL; t++) begin
            if (mask[t]) model_push(t, 8'(base + 16*t));
        end
    endtask

    // Holds a request until accepted or budget expires; push_mask is driven alongside in the first cycle only.
    task automatic req(input int tree, input int budget, input logic [3:0] push_mask, output bit acc);
        bit         rdy;
        bit         first;
        logic [7:0] d;
        acc   = 1'b0;
        first = 1'b1;
        i_req_valid = 1'b1;
        i_req_tree  = 2'(tree);
        i_push_mon  = push_mask;
        for (int c = 0; c < budget && !acc; c++) begin
            @(negedge clk);
            rdy = o_req_ready;
            tick();
            if (rdy) begin
                acc = 1'b1;
                if (occ_m[tree] == 0) begin
                    errs_m++;
                    check("err_pulse", 32'(o_req_err), 32'd1);
                    check("err_no_pop", 32'(o_pop), 32'd0);
                end else begin
                    pops_m++;
                    occ_m[tree]--;
                    d = exp_q[tree].pop_front();
                    sb.push_back({2'(tree), d});
                    check("pop_onehot", 32'(o_pop), 32'(4'(1) << tree));
                    check("pop_no_err", 32'(o_req_err), 32'd0);
                end
            end
            if (first) begin
                first = 1'b0;
                i_push_mon = '0;
                for (int t = 0; t < LEVEL; t++) begin
                    if (push_mask[t]) model_push(t, 8'(100 + t));
                end
            end
        end
        i_req_valid = 1'b0;
        if (acc) check("occ_after_req", 32'(o_occ[tree*CNT_W +: CNT_W]), 32'(occ_m[tree]));
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) tick();
        check("drain", sb.size(), 0);
    endtask

    // Behavioural PIFO lanes: data for a pop appears one cycle after o_pop is seen.
    initial begin
        logic [LEVEL-1:0] seen;
        forever begin
            @(negedge clk);
            seen = o_pop;
            @(posedge clk);
            #1;
            for (int t = 0; t < LEVEL; t++) begin
                if (seen[t] && pifo_q[t].size() > 0) i_pop_data[t*PTW +: PTW] = pifo_q[t].pop_front();
            end
        end
    end

    // Scoreboard monitor: every handshake on the output stream must match the oldest expected element.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!i_rst && o_deq_valid && i_deq_ready) begin
                if (sb.size() == 0) begin
                    check("deq_unexpected", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("deq_elem", 32'({o_deq_tree, o_deq_data}), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int trees4 [4] = '{0, 1, 3, 0};

        i_rst       = 1'b1;
        i_push_mon  = '0;
        i_req_valid = 1'b0;
        i_req_tree  = '0;
        i_pop_data  = '0;
        i_deq_ready = 1'b1;
        for (int t = 0; t < LEVEL; t++) occ_m[t] = 0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", 32'(o_req_ready), 32'd0);
        check("rst_pop", 32'(o_pop), 32'd0);
        check("rst_err", 32'(o_req_err), 32'd0);
        check("rst_deq_valid", 32'(o_deq_valid), 32'd0);
        check("rst_deq_data", 32'(o_deq_data), 32'd0);
        check("rst_deq_tree", 32'(o_deq_tree), 32'd0);
        check("rst_occ", o_occ, 32'd0);
        check("tree_id", 32'(o_tree_id), 32'h0000_00e4);
        i_rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(o_req_ready), 32'd1);

        // Fill all lanes, then one pop per tree in order
        for (int i = 0; i < 4; i++) push_cycle(4'hf, i + 1);
        check("occ_after_push", o_occ, 32'h0404_0404);
        for (int t = 0; t < LEVEL; t++) begin
            req(t, 4, 4'h0, acc);
            check("basic_acc", 32'(acc), 32'd1);
        end
        wait_drain(20);
        check("occ_after_pops", o_occ, 32'h0303_0303);

        // Empty tree 2, then an errored request
        for (int i = 0; i < 3; i++) begin
            req(2, 4, 4'h0, acc);
            check("empty2_acc", 32'(acc), 32'd1);
        end
        wait_drain(20);
        check("occ2_zero", 32'(o_occ[2*CNT_W +: CNT_W]), 32'd0);
        req(2, 4, 4'h0, acc);
        check("err_acc", 32'(acc), 32'd1);
        tick();
        check("err_one_cycle", 32'(o_req_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("err_no_deq", 32'(o_deq_valid), 32'd0);
            tick();
        end

        // Backpressure: credit limits acceptance to the queue depth
        i_deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(trees4[i], 4, 4'h0, acc);
            check("bp_acc", 32'(acc), 32'd1);
        end
        req(1, 8, 4'h0, acc);
        check("bp_blocked", 32'(acc), 32'd0);
        check("bp_ready_low", 32'(o_req_ready), 32'd0);
        check("bp_deq_valid", 32'(o_deq_valid), 32'd1);
        i_deq_ready = 1'b1;
        req(1, 20, 4'h0, acc);
        check("bp_resume1", 32'(acc), 32'd1);
        req(3, 20, 4'h0, acc);
        check("bp_resume2", 32'(acc), 32'd1);
        wait_drain(30);

        // Same-cycle push and pop on one tree, then saturation
        push_cycle(4'b0010, 90);
        check("occ1_two", 32'(o_occ[1*CNT_W +: CNT_W]), 32'd2);
        req(1, 4, 4'b0010, acc);
        check("same_cyc_acc", 32'(acc), 32'd1);
        check("same_cyc_occ", 32'(o_occ[1*CNT_W +: CNT_W]), 32'd2);
        wait_drain(20);
        while (occ_m[3] < 255) push_cycle(4'b1000, 0);
        check("occ3_max", 32'(o_occ[3*CNT_W +: CNT_W]), 32'd255);
        push_cycle(4'b1000, 0);
        check("occ3_sat", 32'(o_occ[3*CNT_W +: CNT_W]), 32'd255);
        check("occ_all", o_occ, {8'(occ_m[3]), 8'(occ_m[2]), 8'(occ_m[1]), 8'(occ_m[0])});
`ifdef PIFO_POP_STATS_EN
        check("stat_pops", o_stat_pops, 32'(pops_m));
        check("stat_errs", o_stat_errs, 32'(errs_m));
`endif

        // Reset with a pop in flight
        req(0, 4, 4'h0, acc);
        check("flight_acc", 32'(acc), 32'd1);
        i_rst = 1'b1;
        sb.delete();
        for (int t = 0; t < LEVEL; t++) begin
            pifo_q[t].delete();
            exp_q[t].delete();
            occ_m[t] = 0;
        end
        repeat (2) tick();
        i_rst = 1'b0;
        tick();
        check("rst2_ready", 32'(o_req_ready), 32'd1);
        check("rst2_occ", o_occ, 32'd0);
`ifdef PIFO_POP_STATS_EN
        check("rst2_stat_pops", o_stat_pops, 32'd0);
        check("rst2_stat_errs", o_stat_errs, 32'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            check("rst2_no_deq", 32'(o_deq_valid), 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
